// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, condition-code register (CCR),
// branch resolution, and the EX/MEM pipeline register feeding MEM.
module ex_stage #(
  parameter int DW = 8,
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic [2:0]    BType,
  input  logic [1:0]    MemToReg,
  input  logic          RegWrite,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic          UpdateFlags,
  input  logic [1:0]    RegDistidx,
  input  logic [1:0]    ALU_src,
  input  logic [3:0]    ALU_op,
  input  logic          IO_Write,
  input  logic          isCall,
  input  logic [DW-1:0] ra_val,
  input  logic [DW-1:0] rb_val,
  input  logic [DW-1:0] imm,
  input  logic [DW-1:0] IP,
  input  logic [DW-1:0] pc_plus1,
  input  logic [RW-1:0] ra,
  input  logic [RW-1:0] rb,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_regwrite,
  input  logic [DW-1:0] wb_data,
  output logic          branch_taken,
  output logic [DW-1:0] branch_target,
  output logic [3:0]    flags,
  output logic [1:0]    MemToReg_out,
  output logic          RegWrite_out,
  output logic          MemWrite_out,
  output logic          MemRead_out,
  output logic          IO_Write_out,
  output logic          isCall_out,
  output logic [RW-1:0] rd_out,
  output logic [DW-1:0] result_out,
  output logic [DW-1:0] store_data_out,
  output logic [DW-1:0] pc_plus1_out
);

  localparam logic [3:0] OP_NOP  = 4'd0,  OP_MOV  = 4'd1,  OP_ADD  = 4'd2,  OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_RLC  = 4'd6,  OP_RRC  = 4'd7;
  localparam logic [3:0] OP_SETC = 4'd8,  OP_CLRC = 4'd9,  OP_NOT  = 4'd10, OP_NEG  = 4'd11;
  localparam logic [3:0] OP_INC  = 4'd12, OP_DEC  = 4'd13, OP_PASS = 4'd14;

  localparam logic [2:0] BR_JZ = 3'd1, BR_JN = 3'd2, BR_JC = 3'd3, BR_JV = 3'd4, BR_JMP = 3'd5;

  // CCR bit order {V,C,N,Z}
  logic [3:0]    ccr_reg, ccr_next;
  logic [DW-1:0] fwd_a, fwd_b, op_b;
  logic [DW-1:0] alu_res;
  logic [DW:0]   ext;
  logic          zn_wr, c_wr, c_val, v_wr, v_val;
  logic [RW-1:0] rd_sel;

  // EX/MEM result has priority over MEM/WB since it is the younger producer
  always_comb begin
    fwd_a = ra_val;
    if (RegWrite_out && rd_out == ra)        fwd_a = result_out;
    else if (wb_regwrite && wb_rd == ra)     fwd_a = wb_data;
    fwd_b = rb_val;
    if (RegWrite_out && rd_out == rb)        fwd_b = result_out;
    else if (wb_regwrite && wb_rd == rb)     fwd_b = wb_data;
  end

  always_comb begin
    case (ALU_src)
      2'd0:    op_b = fwd_b;
      2'd1:    op_b = imm;
      2'd2:    op_b = IP;
      default: op_b = pc_plus1;
    endcase
  end

  always_comb begin
    alu_res = '0;
    ext     = '0;
    zn_wr   = 1'b1;
    c_wr    = 1'b0;
    c_val   = ccr_reg[2];
    v_wr    = 1'b0;
    v_val   = 1'b0;
    case (ALU_op)
      OP_NOP:  zn_wr = 1'b0;
      OP_MOV:  alu_res = op_b;
      OP_ADD: begin
        ext     = {1'b0, fwd_a} + {1'b0, op_b};
        alu_res = ext[DW-1:0];
        c_wr    = 1'b1;
        c_val   = ext[DW];
        v_wr    = 1'b1;
        v_val   = (fwd_a[DW-1] == op_b[DW-1]) && (alu_res[DW-1] != fwd_a[DW-1]);
      end
      OP_SUB: begin
        ext     = {1'b0, fwd_a} - {1'b0, op_b};
        alu_res = ext[DW-1:0];
        c_wr    = 1'b1;
        c_val   = ext[DW];
        v_wr    = 1'b1;
        v_val   = (fwd_a[DW-1] != op_b[DW-1]) && (alu_res[DW-1] != fwd_a[DW-1]);
      end
      OP_AND:  alu_res = fwd_a & op_b;
      OP_OR:   alu_res = fwd_a | op_b;
      OP_RLC: begin
        alu_res = {fwd_a[DW-2:0], ccr_reg[2]};
        c_wr    = 1'b1;
        c_val   = fwd_a[DW-1];
      end
      OP_RRC: begin
        alu_res = {ccr_reg[2], fwd_a[DW-1:1]};
        c_wr    = 1'b1;
        c_val   = fwd_a[0];
      end
      OP_SETC: begin
        c_wr  = 1'b1;
        c_val = 1'b1;
      end
      OP_CLRC: begin
        c_wr  = 1'b1;
        c_val = 1'b0;
      end
      OP_NOT:  alu_res = ~op_b;
      OP_NEG: begin
        ext     = {(DW+1){1'b0}} - {1'b0, op_b};
        alu_res = ext[DW-1:0];
        c_wr    = 1'b1;
        c_val   = ext[DW];
      end
      OP_INC: begin
        ext     = {1'b0, op_b} + {{DW{1'b0}}, 1'b1};
        alu_res = ext[DW-1:0];
        c_wr    = 1'b1;
        c_val   = ext[DW];
      end
      OP_DEC: begin
        ext     = {1'b0, op_b} - {{DW{1'b0}}, 1'b1};
        alu_res = ext[DW-1:0];
        c_wr    = 1'b1;
        c_val   = ext[DW];
      end
      OP_PASS: alu_res = fwd_a;
      default: zn_wr = 1'b0;
    endcase
  end

  // Conditions test the registered CCR; a stalled instruction must not redirect
  always_comb begin
    case (BType)
      BR_JZ:   branch_taken = ccr_reg[0];
      BR_JN:   branch_taken = ccr_reg[1];
      BR_JC:   branch_taken = ccr_reg[2];
      BR_JV:   branch_taken = ccr_reg[3];
      BR_JMP:  branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
    if (stall) branch_taken = 1'b0;
  end

  assign branch_target = fwd_b;
  assign flags         = ccr_reg;

  always_comb begin
    ccr_next = ccr_reg;
    if (UpdateFlags) begin
      if (zn_wr) begin
        ccr_next[0] = (alu_res == '0);
        ccr_next[1] = alu_res[DW-1];
      end
      if (c_wr) ccr_next[2] = c_val;
      if (v_wr) ccr_next[3] = v_val;
    end
    // Consuming a flag via a taken branch beats any write from the same op
    if (branch_taken) begin
      case (BType)
        BR_JZ:   ccr_next[0] = 1'b0;
        BR_JN:   ccr_next[1] = 1'b0;
        BR_JC:   ccr_next[2] = 1'b0;
        BR_JV:   ccr_next[3] = 1'b0;
        default: ccr_next = ccr_next;
      endcase
    end
  end

  always_comb begin
    case (RegDistidx)
      2'd0:    rd_sel = ra;
      2'd1:    rd_sel = rb;
      default: rd_sel = {RW{1'b1}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ccr_reg <= '0;
    end else if (!stall && !flush) begin
      ccr_reg <= ccr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (flush && !stall)) begin
      MemToReg_out   <= '0;
      RegWrite_out   <= 1'b0;
      MemWrite_out   <= 1'b0;
      MemRead_out    <= 1'b0;
      IO_Write_out   <= 1'b0;
      isCall_out     <= 1'b0;
      rd_out         <= '0;
      result_out     <= '0;
      store_data_out <= '0;
      pc_plus1_out   <= '0;
    end else if (!stall) begin
      MemToReg_out   <= MemToReg;
      RegWrite_out   <= RegWrite;
      MemWrite_out   <= MemWrite;
      MemRead_out    <= MemRead;
      IO_Write_out   <= IO_Write;
      isCall_out     <= isCall;
      rd_out         <= rd_sel;
      result_out     <= alu_res;
      store_data_out <= fwd_a;
      pc_plus1_out   <= pc_plus1;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed-vector bench for ex_stage with hand-computed expectations.
module tb_ex_stage;

  logic       clk = 1'b0;
  logic       rst, stall, flush;
  logic [2:0] BType;
  logic [1:0] MemToReg, RegDistidx, ALU_src;
  logic       RegWrite, MemWrite, MemRead, UpdateFlags, IO_Write, isCall;
  logic [3:0] ALU_op;
  logic [7:0] ra_val, rb_val, imm, IP, pc_plus1, wb_data;
  logic [1:0] ra, rb, wb_rd;
  logic       wb_regwrite;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [3:0] flags;
  logic [1:0] MemToReg_out;
  logic       RegWrite_out, MemWrite_out, MemRead_out, IO_Write_out, isCall_out;
  logic [1:0] rd_out;
  logic [7:0] result_out, store_data_out, pc_plus1_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage #(.DW(8), .RW(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .BType(BType), .MemToReg(MemToReg), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .MemRead(MemRead), .UpdateFlags(UpdateFlags), .RegDistidx(RegDistidx),
    .ALU_src(ALU_src), .ALU_op(ALU_op), .IO_Write(IO_Write), .isCall(isCall),
    .ra_val(ra_val), .rb_val(rb_val), .imm(imm), .IP(IP), .pc_plus1(pc_plus1),
    .ra(ra), .rb(rb), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
    .branch_taken(branch_taken), .branch_target(branch_target), .flags(flags),
    .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out), .MemWrite_out(MemWrite_out),
    .MemRead_out(MemRead_out), .IO_Write_out(IO_Write_out), .isCall_out(isCall_out),
    .rd_out(rd_out), .result_out(result_out), .store_data_out(store_data_out),
    .pc_plus1_out(pc_plus1_out)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic clear_in();
    stall = 0; flush = 0; BType = 0; MemToReg = 0; RegWrite = 0; MemWrite = 0;
    MemRead = 0; UpdateFlags = 0; RegDistidx = 0; ALU_src = 0; ALU_op = 0;
    IO_Write = 0; isCall = 0; ra_val = 0; rb_val = 0; imm = 0; IP = 0;
    pc_plus1 = 0; ra = 0; rb = 0; wb_rd = 0; wb_regwrite = 0; wb_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic uf, input logic rw);
    clear_in();
    ALU_op = op; ra_val = a; rb_val = b; UpdateFlags = uf; RegWrite = rw;
    ra = 2'd0; rb = 2'd1; RegDistidx = 2'd2;
  endtask

  initial begin
    // Reset with busy inputs
    clear_in();
    rst = 1; ALU_op = 4'd2; ra_val = 8'h7F; rb_val = 8'h01; RegWrite = 1;
    MemWrite = 1; UpdateFlags = 1; pc_plus1 = 8'h33; isCall = 1; RegDistidx = 2'd2;
    step();
    check("rst_result", result_out, 8'h00);
    check("rst_flags", 8'(flags), 8'h0);
    check("rst_regwrite", 8'(RegWrite_out), 8'h0);
    check("rst_pc1", pc_plus1_out, 8'h00);
    step();
    check("rst_rd", 8'(rd_out), 8'h0);
    check("rst_call", 8'(isCall_out), 8'h0);
    rst = 0;

    // ADD 7F+01: overflow into sign bit
    clear_in();
    ALU_op = 4'd2; ra_val = 8'h7F; rb_val = 8'h01; UpdateFlags = 1; RegWrite = 1;
    ra = 2'd0; rb = 2'd2;
    step();
    check("add_result", result_out, 8'h80);
    check("add_flags", 8'(flags), 8'b1010);
    check("add_regwrite", 8'(RegWrite_out), 8'h1);
    check("add_store", store_data_out, 8'h7F);

    // MOV R1<-55 then ADD R0,R1 back-to-back; conflicting WB value must lose
    clear_in();
    ALU_op = 4'd1; ALU_src = 2'd1; imm = 8'h55; ra = 2'd1; RegWrite = 1;
    step();
    check("mov_result", result_out, 8'h55);
    check("mov_rd", 8'(rd_out), 8'h1);
    check("mov_flags_kept", 8'(flags), 8'b1010);
    clear_in();
    ALU_op = 4'd2; ra = 2'd0; rb = 2'd1; ra_val = 8'h01; rb_val = 8'h00; RegWrite = 1;
    wb_regwrite = 1; wb_rd = 2'd1; wb_data = 8'hAA;
    step();
    check("fwd_exmem", result_out, 8'h56);

    // Same with a one-cycle gap: WB forward
    clear_in();
    ALU_op = 4'd1; ALU_src = 2'd1; imm = 8'h55; ra = 2'd1; RegWrite = 1;
    step();
    clear_in();
    step();
    clear_in();
    ALU_op = 4'd2; ra = 2'd0; rb = 2'd1; ra_val = 8'h01; rb_val = 8'h00; RegWrite = 1;
    wb_regwrite = 1; wb_rd = 2'd1; wb_data = 8'h55;
    step();
    check("fwd_wb", result_out, 8'h56);
    // No forward source: stale value used (rd_out=0, rb=1)
    clear_in();
    ALU_op = 4'd2; ra = 2'd2; rb = 2'd1; ra_val = 8'h01; rb_val = 8'h00;
    step();
    check("no_fwd", result_out, 8'h01);

    // SUB 5-5 sets Z, then JZ
    alu(4'd3, 8'h05, 8'h05, 1'b1, 1'b0);
    step();
    check("sub_zero_flags", 8'(flags), 8'b0001);
    clear_in();
    BType = 3'd1; rb = 2'd2; rb_val = 8'h40;
    #1;
    check("jz_taken", 8'(branch_taken), 8'h1);
    check("jz_target", branch_target, 8'h40);
    stall = 1;
    #1;
    check("jz_stall_gate", 8'(branch_taken), 8'h0);
    stall = 0;
    step();
    check("jz_clears_z", 8'(flags), 8'b0000);
    #1;
    check("jz_not_taken", 8'(branch_taken), 8'h0);
    BType = 3'd6;
    #1;
    check("btype6", 8'(branch_taken), 8'h0);

    // CALL: unconditional, keeps its own EX/MEM entry
    clear_in();
    BType = 3'd5; isCall = 1; RegWrite = 1; RegDistidx = 2'd2; pc_plus1 = 8'h21;
    rb = 2'd2; rb_val = 8'h90;
    #1;
    check("call_taken", 8'(branch_taken), 8'h1);
    check("call_target", branch_target, 8'h90);
    step();
    check("call_iscall", 8'(isCall_out), 8'h1);
    check("call_pc1", pc_plus1_out, 8'h21);
    check("call_rd_sp", 8'(rd_out), 8'h3);

    // Stall holds EX/MEM and CCR for 3 cycles
    alu(4'd2, 8'h10, 8'h20, 1'b1, 1'b1);
    step();
    check("add2_result", result_out, 8'h30);
    alu(4'd2, 8'hF0, 8'h20, 1'b1, 1'b1);
    MemWrite = 1;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_result", result_out, 8'h30);
      check("stall_flags", 8'(flags), 8'b0000);
    end
    stall = 0;
    step();
    check("unstall_result", result_out, 8'h10);
    check("unstall_flags", 8'(flags), 8'b0100);
    // Stall and flush together: stall wins
    stall = 1; flush = 1;
    step();
    check("stallflush_mw", 8'(MemWrite_out), 8'h1);
    // Flush alone: bubble, CCR untouched
    stall = 0;
    alu(4'd3, 8'h01, 8'h01, 1'b1, 1'b1);
    MemWrite = 1; flush = 1;
    step();
    check("flush_regwrite", 8'(RegWrite_out), 8'h0);
    check("flush_memwrite", 8'(MemWrite_out), 8'h0);
    check("flush_flags", 8'(flags), 8'b0100);

    // SETC then RLC 81 with C=1
    alu(4'd8, 8'h00, 8'h00, 1'b1, 1'b0);
    step();
    check("setc_c", 8'(flags[2]), 8'h1);
    alu(4'd6, 8'h81, 8'h00, 1'b1, 1'b0);
    step();
    check("rlc_result", result_out, 8'h03);
    check("rlc_flags", 8'(flags), 8'b0100);
    // JC taken while also SETC: the clear wins
    alu(4'd8, 8'h00, 8'h00, 1'b1, 1'b0);
    BType = 3'd3;
    #1;
    check("jc_taken", 8'(branch_taken), 8'h1);
    step();
    check("jc_clear_prio", 8'(flags), 8'b0001);
    // RRC 02 with C=0
    alu(4'd7, 8'h02, 8'h00, 1'b1, 1'b0);
    step();
    check("rrc_result", result_out, 8'h01);
    check("rrc_flags", 8'(flags), 8'b0000);
    // SUB with borrow
    alu(4'd3, 8'h03, 8'h05, 1'b1, 1'b0);
    step();
    check("sub_borrow_result", result_out, 8'hFE);
    check("sub_borrow_flags", 8'(flags), 8'b0110);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 8-bit pipelined core; sits directly downstream of the ID/EX pipeline register and consumes its outputs.
- Selects operands with forwarding, performs the ALU operation, and maintains the condition-code register (CCR: Z,N,C,V).
- Resolves branches and owns the EX/MEM pipeline register.
- The MEM stage consumes its registered outputs.

Parameters:
- DW, 8, datapath width
- RW, 2, register-address width (4 GPRs)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  hold EX/MEM register and CCR
- flush  in  1  load bubble into EX/MEM register
- BType, MemToReg, RegWrite, MemWrite, MemRead, UpdateFlags, RegDistidx, ALU_src, ALU_op, IO_Write, isCall  in  3/2/1/1/1/1/2/2/4/1/1  control from ID/EX
- ra_val, rb_val, imm, IP, pc_plus1  in  8 each  data from ID/EX
- ra, rb  in  2 each  source addresses
- wb_rd  in  2  MEM/WB destination
- wb_regwrite  in  1  MEM/WB write enable
- wb_data  in  8  MEM/WB write-back value
- branch_taken  out  1  combinational; redirect PC, flush IF/ID and ID/EX
- branch_target  out  8  combinational; forwarded operand B
- flags  out  4  CCR {V,C,N,Z}
- MemToReg_out, RegWrite_out, MemWrite_out, MemRead_out, IO_Write_out, isCall_out  out  2/1/1/1/1/1  registered EX/MEM control
- rd_out  out  2  registered destination (ra when RegDistidx==0, rb when 1, 2'd3 (SP) otherwise)
- result_out  out  8  registered ALU result
- store_data_out  out  8  registered forwarded operand A
- pc_plus1_out  out  8  registered return address

Behaviour:
- Reset (rst high at posedge): all registered outputs 0, CCR 0. Reset overrides stall and flush.
- Forwarding for each source (ra, rb):
  - If RegWrite_out and rd_out==src, use result_out (EX/MEM priority).
  - Else if wb_regwrite and wb_rd==src, use wb_data.
  - Else use the ID/EX value.
- Operand A = forwarded ra.
- Operand B by ALU_src: 0 forwarded rb, 1 imm, 2 IP, 3 pc_plus1.
- ALU_op encoding (result 8-bit, mod 256):
  - 0 NOP: result 0, no flag write.
  - 1 MOV: B.
  - 2 ADD: A+B, C = carry out, V = signed overflow.
  - 3 SUB: A-B, C = borrow (A<B unsigned), V = signed overflow.
  - 4 AND, 5 OR.
  - 6 RLC: {A[6:0],C}, C<=A[7].
  - 7 RRC: {C,A[7:1]}, C<=A[0].
  - 8 SETC: C<=1. 9 CLRC: C<=0.
  - 10 NOT: ~B. 11 NEG: 0-B. 12 INC: B+1. 13 DEC: B-1.
  - 14 PASS_A: A.
  - 15 reserved: result 0, no flag write.
- Flag update rules:
  - Z and N are computed from the result and written only when UpdateFlags=1.
  - C is written when UpdateFlags=1 and the op is ADD, SUB, RLC, RRC, SETC, CLRC, NEG, INC or DEC.
  - V is written only on ADD/SUB.
- CCR timing: updates at posedge when not stall and not flush. Branches read the registered CCR; the updated value is visible to the next instruction.
- BType encoding: 0 none, 1 JZ, 2 JN, 3 JC, 4 JV, 5 JMP/CALL unconditional, 6–7 resolved downstream (branch_taken=0).
- branch_taken: combinational when the condition is met. Gated to 0 while stall=1.
- Taken conditional branch clears the tested flag at the same posedge. This takes priority over any flag write from the same instruction.
- EX/MEM register, per posedge:
  - rst: cleared.
  - Else stall: hold all outputs.
  - Else flush: all control outputs 0, data outputs 0.
  - Else capture.
- Pipeline timing: latency 1 cycle from ID/EX to EX/MEM. One instruction per cycle.
- Simultaneous stall and flush: stall wins.
- A taken branch does not flush its own EX/MEM entry (needed for isCall).

Test Plan:
- rst=1 for 2 cycles with nonzero inputs -> all outputs 0, flags=0 after the first posedge.
- ADD ra_val=8'h7F, rb_val=8'h01, UpdateFlags=1 -> result_out=8'h80, flags next cycle {V,C,N,Z}=4'b1010.
- Back-to-back: MOV R1<-imm 8'h55 then ADD R0,R1 (rb=1, stale rb_val=0, ra_val=1) -> second result_out=8'h56 via EX/MEM forward. Same with 1-cycle gap -> wb_data forward used.
- SUB 8'h05-8'h05 then JZ with rb_val=8'h40 -> branch_taken=1, branch_target=8'h40, Z cleared next cycle. Repeat JZ with Z=0 -> branch_taken=0.
- stall=1 for 3 cycles during ADD -> outputs and flags frozen. flush=1 with stall=0 -> RegWrite_out=0, MemWrite_out=0; CCR unchanged.
- RLC A=8'h81, C=1 -> result 8'h03, C=1. RRC A=8'h02, C=0 -> result 8'h01, C=0.
